// File: rtl/mac_table_arb_pkg.sv
// Shared types and default sizing for the MAC table request arbiter.
// The optional aging feature is selected with MAC_TABLE_ARB_AGING_EN.
package mac_arb_pkg;

  localparam int P_PORTS_DEF    = 4;
  localparam int P_ADDR_W_DEF   = 8;
  localparam int P_AGE_TICK_DEF = 32768;

  // Arbiter FSM: one table transaction takes exactly one pass round the loop.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mac_table_arb_if.sv
// Port-side and table-side signal bundle of mac_table_arb.
// Handshake: i_req[p] is a one-cycle valid with no ready; the arbiter always
// accepts it into port p's holding slot unless that slot is already pending
// and not being granted, in which case the pulse is dropped and o_ovf[p]
// pulses the next cycle. o_ack[p] is the one-cycle completion for port p and
// o_dst_port is meaningful only while o_ack is non-zero. The table side is a
// fire-and-forget write strobe plus a read whose data returns one cycle later.
interface mac_table_arb_if
  import mac_arb_pkg::*;
#(
  parameter int pPORTS  = P_PORTS_DEF,
  parameter int pADDR_W = P_ADDR_W_DEF,
  parameter int pPORT_W = $clog2(pPORTS)
);

  logic [pPORTS-1:0]         i_req;
  logic [pPORTS*pADDR_W-1:0] i_sa;
  logic [pPORTS*pADDR_W-1:0] i_da;
  logic [pPORTS-1:0]         o_ack;
  logic [pPORT_W-1:0]        o_dst_port;
  logic [pPORTS-1:0]         o_ovf;
  logic                      o_tbl_we;
  logic [pADDR_W-1:0]        o_tbl_sa;
  logic [pADDR_W-1:0]        o_tbl_da;
  logic [pPORT_W-1:0]        o_tbl_port;
  logic [pPORT_W-1:0]        i_tbl_port;
  logic                      o_age_step;
  logic                      o_busy;
  arb_state_e                dbg_state;

  // Requesters and table model side.
  modport master (
    output i_req, i_sa, i_da, i_tbl_port,
    input  o_ack, o_dst_port, o_ovf, o_tbl_we, o_tbl_sa, o_tbl_da,
    input  o_tbl_port, o_age_step, o_busy, dbg_state
  );

  // Arbiter side.
  modport slave (
    input  i_req, i_sa, i_da, i_tbl_port,
    output o_ack, o_dst_port, o_ovf, o_tbl_we, o_tbl_sa, o_tbl_da,
    output o_tbl_port, o_age_step, o_busy, dbg_state
  );

endinterface

// File: rtl/mac_table_arb_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping at N-1 back to 0.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan offsets 0..N-1 from the pointer; the first hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!any && req[j] && (((int'(ptr) + i) % N) == j)) begin
          any    = 1'b1;
          gnt[j] = 1'b1;
          idx    = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/mac_table_arb.sv
// MAC table request arbiter: collects per-port learn/lookup requests, grants
// them round-robin, learns SA->port and looks up DA in an external table with
// one-cycle read latency, then acks the port with the looked-up egress port.
// A request lands in the pending register first, so the grant happens in the
// following IDLE cycle and the ack arrives four cycles after the request.
// Optional periodic aging strobe: define MAC_TABLE_ARB_AGING_EN.
module mac_table_arb
  import mac_arb_pkg::*;
#(
  parameter int pPORTS    = P_PORTS_DEF,
  parameter int pADDR_W   = P_ADDR_W_DEF,
  parameter int pPORT_W   = $clog2(pPORTS),
  parameter int pAGE_TICK = P_AGE_TICK_DEF
) (
  input logic              iclk,
  input logic              i_rst,
  mac_table_arb_if.slave   bus
);

  arb_state_e                        state_q, state_d;
  logic [pPORTS-1:0]                 pending_q, pending_d;
  logic [pPORTS-1:0][pADDR_W-1:0]    hold_sa_q, hold_sa_d;
  logic [pPORTS-1:0][pADDR_W-1:0]    hold_da_q, hold_da_d;
  logic [pPORT_W-1:0]                ptr_q, ptr_d;
  logic [pADDR_W-1:0]                iss_sa_q, iss_sa_d;
  logic [pADDR_W-1:0]                iss_da_q, iss_da_d;
  logic [pPORT_W-1:0]                iss_idx_q, iss_idx_d;
  logic [pPORT_W-1:0]                dst_q, dst_d;
  logic [pPORTS-1:0]                 ack_q, ack_d;
  logic [pPORTS-1:0]                 ovf_q, ovf_d;
  logic                              tbl_we_q, tbl_we_d;
  logic                              age_step_q, age_step_d;

  logic [pPORTS-1:0]                 gnt_vec, gnt_eff;
  logic [pPORT_W-1:0]                gnt_idx;
  logic                              gnt_any;
  logic                              grant_fire;
  logic                              age_serve;

  rr_arbiter #(.N(pPORTS), .IW(pPORT_W)) u_rr (
    .req (pending_q),
    .ptr (ptr_q),
    .gnt (gnt_vec),
    .idx (gnt_idx),
    .any (gnt_any)
  );

`ifdef MAC_TABLE_ARB_AGING_EN
  localparam int AGE_CW = (pAGE_TICK > 1) ? $clog2(pAGE_TICK) : 1;

  logic [AGE_CW-1:0] age_cnt_q, age_cnt_d;
  logic              age_pending_q, age_pending_d;
  logic              age_wrap;

  // Free-running aging counter; a wrap while a step is still owed merges.
  always_comb begin
    age_wrap      = (age_cnt_q == AGE_CW'(pAGE_TICK - 1));
    age_cnt_d     = age_wrap ? '0 : age_cnt_q + AGE_CW'(1);
    age_serve     = (state_q == ST_IDLE) && age_pending_q;
    age_pending_d = (age_pending_q & ~age_serve) | age_wrap;
  end

  // Aging counter and owed-step flag.
  always_ff @(posedge iclk or posedge i_rst) begin
    if (i_rst) begin
      age_cnt_q     <= '0;
      age_pending_q <= 1'b0;
    end else begin
      age_cnt_q     <= age_cnt_d;
      age_pending_q <= age_pending_d;
    end
  end
`else
  logic unused_age_tick;

  assign age_serve       = 1'b0;
  assign unused_age_tick = ^pAGE_TICK;
`endif

  // An owed aging step takes IDLE ahead of any pending port.
  assign grant_fire = (state_q == ST_IDLE) && !age_serve && gnt_any;
  assign gnt_eff    = grant_fire ? gnt_vec : '0;

  // Per-port capture: a slot accepts a new request when empty or being
  // granted this cycle; otherwise the pulse is dropped and flagged.
  always_comb begin
    pending_d = pending_q;
    hold_sa_d = hold_sa_q;
    hold_da_d = hold_da_q;
    ovf_d     = '0;
    for (int p = 0; p < pPORTS; p++) begin
      pending_d[p] = (pending_q[p] & ~gnt_eff[p]) | bus.i_req[p];
      ovf_d[p]     = bus.i_req[p] & pending_q[p] & ~gnt_eff[p];
      if (bus.i_req[p] && (!pending_q[p] || gnt_eff[p])) begin
        hold_sa_d[p] = bus.i_sa[p*pADDR_W +: pADDR_W];
        hold_da_d[p] = bus.i_da[p*pADDR_W +: pADDR_W];
      end
    end
  end

  // FSM next state and registered output values.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    iss_sa_d   = iss_sa_q;
    iss_da_d   = iss_da_q;
    iss_idx_d  = iss_idx_q;
    tbl_we_d   = 1'b0;
    ack_d      = '0;
    dst_d      = '0;
    age_step_d = age_serve;
    case (state_q)
      ST_IDLE: begin
        if (grant_fire) begin
          state_d   = ST_ISSUE;
          iss_sa_d  = hold_sa_q[gnt_idx];
          iss_da_d  = hold_da_q[gnt_idx];
          iss_idx_d = gnt_idx;
          tbl_we_d  = 1'b1;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        state_d = ST_DONE;
        dst_d   = bus.i_tbl_port;
        ack_d   = pPORTS'(1) << iss_idx_q;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = (iss_idx_q == pPORT_W'(pPORTS - 1)) ? '0
                                                       : iss_idx_q + pPORT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All arbiter state and registered outputs.
  always_ff @(posedge iclk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      hold_sa_q  <= '0;
      hold_da_q  <= '0;
      ptr_q      <= '0;
      iss_sa_q   <= '0;
      iss_da_q   <= '0;
      iss_idx_q  <= '0;
      dst_q      <= '0;
      ack_q      <= '0;
      ovf_q      <= '0;
      tbl_we_q   <= 1'b0;
      age_step_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      hold_sa_q  <= hold_sa_d;
      hold_da_q  <= hold_da_d;
      ptr_q      <= ptr_d;
      iss_sa_q   <= iss_sa_d;
      iss_da_q   <= iss_da_d;
      iss_idx_q  <= iss_idx_d;
      dst_q      <= dst_d;
      ack_q      <= ack_d;
      ovf_q      <= ovf_d;
      tbl_we_q   <= tbl_we_d;
      age_step_q <= age_step_d;
    end
  end

  assign bus.o_ack      = ack_q;
  assign bus.o_dst_port = dst_q;
  assign bus.o_ovf      = ovf_q;
  assign bus.o_tbl_we   = tbl_we_q;
  assign bus.o_tbl_sa   = iss_sa_q;
  assign bus.o_tbl_da   = iss_da_q;
  assign bus.o_tbl_port = iss_idx_q;
  assign bus.o_age_step = age_step_q;
  assign bus.o_busy     = (state_q != ST_IDLE);
  assign bus.dbg_state  = state_q;

endmodule
